// File: rtl/ir_pkg.sv
// Shared types and default constants for the IR move scheduler.
package ir_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } sched_state_t;

    localparam int DEPTH_DEF = 4;
    localparam int STEP_DEF  = 8;
    localparam int X_MAX_DEF = 639;
    localparam int Y_MAX_DEF = 479;

endpackage

// File: rtl/ir_dir_fifo.sv
// DEPTH-entry, 2-bit-wide synchronous FIFO holding queued move directions.
// A push while full is accepted only when a pop happens in the same cycle.
module ir_dir_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    din,
    output logic [1:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: storage is not reset; entries are only read behind a valid count, so
    // leaving it out keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state always uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ir_move_scheduler.sv
// Queues IR direction strobes and applies at most one saturating position move
// per video frame, so the drawing logic only sees changes aligned to vblank.
module ir_move_scheduler
    import ir_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int STEP  = STEP_DEF,
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Readable,
    input  logic                     Up,
    input  logic                     Down,
    input  logic                     Left,
    input  logic                     Right,
    input  logic                     Frame_Tick,
    output logic [X_W-1:0]           Pos_X,
    output logic [Y_W-1:0]           Pos_Y,
    output logic                     Move_Valid,
    output logic                     Overflow,
    output logic [$clog2(DEPTH):0]   Queue_Count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [X_W:0] XS = (X_W + 1)'(STEP);
    localparam logic [X_W:0] XM = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0] YS = (Y_W + 1)'(STEP);
    localparam logic [Y_W:0] YM = (Y_W + 1)'(Y_MAX);

    sched_state_t   state_q, state_d;
    dir_t           cap_dir, head_dir;
    logic           cap_valid, fifo_push, fifo_pop, fifo_full, fifo_empty, apply_move;
    logic [1:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic [X_W-1:0] pos_x_q, pos_x_d;
    logic [Y_W-1:0] pos_y_q, pos_y_d;
    logic [X_W:0]   x_ext;
    logic [Y_W:0]   y_ext;
    logic           move_valid_q, overflow_q;

    // Fixed priority Up > Down > Left > Right.
    always_comb begin
        cap_dir = DIR_RIGHT;
        if (Up)        cap_dir = DIR_UP;
        else if (Down) cap_dir = DIR_DOWN;
        else if (Left) cap_dir = DIR_LEFT;
    end

    assign cap_valid  = Readable & (Up | Down | Left | Right);
    assign fifo_push  = cap_valid & (~fifo_full | fifo_pop);
    assign head_dir   = dir_t'(fifo_dout);
    assign apply_move = fifo_pop & ~fifo_empty;

    ir_dir_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (cap_dir),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_push)  state_d = ARMED;
            ARMED:   if (Frame_Tick) state_d = APPLY;
            APPLY:   state_d = (fifo_push || fifo_count > CW'(1)) ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = 1'b0;
        case (state_q)
            APPLY:   fifo_pop = 1'b1;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Widen by one bit so the clamp comparisons cannot wrap.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        x_ext   = {1'b0, pos_x_q};
        y_ext   = {1'b0, pos_y_q};
        if (apply_move) begin
            case (head_dir)
                DIR_UP:    pos_y_d = (y_ext < YS) ? '0 : Y_W'(y_ext - YS);
                DIR_DOWN:  pos_y_d = (y_ext + YS > YM) ? Y_W'(Y_MAX) : Y_W'(y_ext + YS);
                DIR_LEFT:  pos_x_d = (x_ext < XS) ? '0 : X_W'(x_ext - XS);
                DIR_RIGHT: pos_x_d = (x_ext + XS > XM) ? X_W'(X_MAX) : X_W'(x_ext + XS);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pos_x_q      <= X_W'(X_MAX / 2);
            pos_y_q      <= Y_W'(Y_MAX / 2);
            move_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            move_valid_q <= apply_move;
            overflow_q   <= cap_valid & fifo_full & ~fifo_pop;
        end
    end

    assign Pos_X       = pos_x_q;
    assign Pos_Y       = pos_y_q;
    assign Move_Valid  = move_valid_q;
    assign Overflow    = overflow_q;
    assign Queue_Count = fifo_count;

endmodule

// File: tb/tb_ir_move_scheduler.sv
// Self-checking bench: encoder vector table, hand-written timing corners and a
// randomized run, all checked against a queue-based reference model.
module tb_ir_move_scheduler;

    localparam int DEPTH = 4;
    localparam int STEP  = 8;
    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    logic                   Clock = 1'b0;
    logic                   Reset, Readable, Up, Down, Left, Right, Frame_Tick;
    logic [X_W-1:0]         Pos_X;
    logic [Y_W-1:0]         Pos_Y;
    logic                   Move_Valid, Overflow;
    logic [$clog2(DEPTH):0] Queue_Count;

    int total = 0;
    int bad   = 0;

    // Reference model: pending commands as a plain queue, position as integers.
    int mq[$];
    int mx, my;
    bit m_apply;
    bit exp_mv, exp_ov;

    typedef struct {
        logic rd, u, d, l, r;
        int   exp_cnt;
        int   exp_x;
        int   exp_y;
    } vec_t;
    vec_t vecs[10];

    ir_move_scheduler #(
        .DEPTH(DEPTH), .STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_W(X_W), .Y_W(Y_W)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Readable    (Readable),
        .Up          (Up),
        .Down        (Down),
        .Left        (Left),
        .Right       (Right),
        .Frame_Tick  (Frame_Tick),
        .Pos_X       (Pos_X),
        .Pos_Y       (Pos_Y),
        .Move_Valid  (Move_Valid),
        .Overflow    (Overflow),
        .Queue_Count (Queue_Count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mx      = X_MAX / 2;
        my      = Y_MAX / 2;
        m_apply = 1'b0;
        exp_mv  = 1'b0;
        exp_ov  = 1'b0;
    endtask

    task automatic model_move(input int dir);
        case (dir)
            0:       my = (my - STEP < 0) ? 0 : my - STEP;
            1:       my = (my + STEP > Y_MAX) ? Y_MAX : my + STEP;
            2:       mx = (mx - STEP < 0) ? 0 : mx - STEP;
            default: mx = (mx + STEP > X_MAX) ? X_MAX : mx + STEP;
        endcase
    endtask

    // A tick is taken when commands are waiting and no move is already in flight;
    // the move lands one edge later.
    task automatic model_step(input logic rd, input logic bu, input logic bd,
                              input logic bl, input logic br, input logic ft);
        bit pop, cap, take_tick, was_full;
        int dir;
        pop       = m_apply;
        cap       = rd && (bu || bd || bl || br);
        take_tick = ft && (mq.size() > 0) && !m_apply;
        was_full  = (mq.size() == DEPTH);
        dir       = bu ? 0 : bd ? 1 : bl ? 2 : 3;
        exp_mv    = 1'b0;
        exp_ov    = 1'b0;
        if (pop) begin
            model_move(mq.pop_front());
            exp_mv = 1'b1;
        end
        if (cap) begin
            if (!was_full || pop) mq.push_back(dir);
            else                  exp_ov = 1'b1;
        end
        m_apply = take_tick;
    endtask

    task automatic check_all();
        check("pos_x", 32'(Pos_X), 32'(mx));
        check("pos_y", 32'(Pos_Y), 32'(my));
        check("move_valid", 32'(Move_Valid), 32'(exp_mv));
        check("overflow", 32'(Overflow), 32'(exp_ov));
        check("queue_count", 32'(Queue_Count), 32'(mq.size()));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1 ns later.
    task automatic cycle(input logic rd, input logic bu, input logic bd,
                         input logic bl, input logic br, input logic ft);
        Readable   = rd;
        Up         = bu;
        Down       = bd;
        Left       = bl;
        Right      = br;
        Frame_Tick = ft;
        @(posedge Clock);
        model_step(rd, bu, bd, bl, br, ft);
        #1;
        check_all();
    endtask

    task automatic idle(); cycle(0, 0, 0, 0, 0, 0); endtask
    task automatic tick(); cycle(0, 0, 0, 0, 0, 1); endtask

    task automatic do_reset();
        Reset      = 1'b1;
        Readable   = 1'b0;
        Up         = 1'b0;
        Down       = 1'b0;
        Left       = 1'b0;
        Right      = 1'b0;
        Frame_Tick = 1'b0;
        #2;
        model_reset();
        check("rst_pos_x", 32'(Pos_X), 32'd319);
        check("rst_pos_y", 32'(Pos_Y), 32'd239);
        check("rst_count", 32'(Queue_Count), 32'd0);
        check("rst_move_valid", 32'(Move_Valid), 32'd0);
        Reset = 1'b0;
    endtask

    initial begin
        int mv_seen;

        // rd, u, d, l, r, queued, X and Y after one tick
        vecs[0] = '{1, 1, 0, 0, 0, 1, 319, 231};
        vecs[1] = '{1, 0, 1, 0, 0, 1, 319, 247};
        vecs[2] = '{1, 0, 0, 1, 0, 1, 311, 239};
        vecs[3] = '{1, 0, 0, 0, 1, 1, 327, 239};
        vecs[4] = '{1, 1, 0, 1, 0, 1, 319, 231};
        vecs[5] = '{1, 0, 1, 0, 1, 1, 319, 247};
        vecs[6] = '{1, 0, 0, 1, 1, 1, 311, 239};
        vecs[7] = '{1, 1, 1, 1, 1, 1, 319, 231};
        vecs[8] = '{1, 0, 0, 0, 0, 0, 319, 239};
        vecs[9] = '{0, 1, 0, 1, 0, 0, 319, 239};

        do_reset();

        // Ticks with an empty queue do nothing.
        tick(); tick(); idle();
        check("empty_tick_no_move", 32'(Move_Valid), 32'd0);

        foreach (vecs[i]) begin
            do_reset();
            cycle(vecs[i].rd, vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, 0);
            check($sformatf("vec%0d_count", i), 32'(Queue_Count), 32'(vecs[i].exp_cnt));
            tick();
            idle();
            check($sformatf("vec%0d_x", i), 32'(Pos_X), 32'(vecs[i].exp_x));
            check($sformatf("vec%0d_y", i), 32'(Pos_Y), 32'(vecs[i].exp_y));
            idle();
        end

        // Latency: tick in cycle N gives the move in N+2, one-cycle pulse.
        do_reset();
        cycle(1, 0, 0, 0, 1, 0);
        tick();
        check("lat_n1_no_move", 32'(Move_Valid), 32'd0);
        idle();
        check("lat_n2_x", 32'(Pos_X), 32'd327);
        check("lat_n2_mv", 32'(Move_Valid), 32'd1);
        idle();
        check("lat_n3_mv", 32'(Move_Valid), 32'd0);
        check("lat_count", 32'(Queue_Count), 32'd0);

        // Saturation at the left and bottom edges.
        do_reset();
        for (int k = 1; k <= 41; k++) begin
            cycle(1, 0, 0, 1, 0, 0);
            tick();
            idle();
            if (k == 39) check("left_39", 32'(Pos_X), 32'd7);
            if (k >= 40) check("left_sat", 32'(Pos_X), 32'd0);
        end
        for (int k = 1; k <= 32; k++) begin
            cycle(1, 0, 1, 0, 0, 0);
            tick();
            idle();
            if (k >= 30) check("down_sat", 32'(Pos_Y), 32'd479);
        end

        // Overflow on the fifth strobe, then FIFO-ordered application.
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check("ovf_pulse", 32'(Overflow), 32'd1);
        check("ovf_count", 32'(Queue_Count), 32'd4);
        idle();
        check("ovf_one_cycle", 32'(Overflow), 32'd0);
        tick(); idle();
        check("fifo_u_y", 32'(Pos_Y), 32'd231);
        tick(); idle();
        check("fifo_d_y", 32'(Pos_Y), 32'd239);
        tick(); idle();
        check("fifo_l_x", 32'(Pos_X), 32'd311);
        tick(); idle();
        check("fifo_r_x", 32'(Pos_X), 32'd319);
        tick(); idle();
        check("fifo_drained_no_move", 32'(Move_Valid), 32'd0);

        // Push while full during APPLY is accepted.
        do_reset();
        repeat (4) cycle(1, 0, 0, 0, 1, 0);
        tick();
        cycle(1, 1, 0, 0, 0, 0);
        check("full_apply_no_ovf", 32'(Overflow), 32'd0);
        check("full_apply_count", 32'(Queue_Count), 32'd4);
        check("full_apply_mv", 32'(Move_Valid), 32'd1);

        // Back-to-back ticks give a single move.
        do_reset();
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        mv_seen = 0;
        tick();  mv_seen += int'(Move_Valid);
        tick();  mv_seen += int'(Move_Valid);
        idle();  mv_seen += int'(Move_Valid);
        idle();  mv_seen += int'(Move_Valid);
        idle();  mv_seen += int'(Move_Valid);
        check("b2b_moves", 32'(mv_seen), 32'd1);
        check("b2b_count", 32'(Queue_Count), 32'd1);

        // Reset with three entries queued and a move in flight.
        do_reset();
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        tick();
        do_reset();
        mv_seen = 0;
        repeat (3) begin
            tick();
            mv_seen += int'(Move_Valid);
        end
        check("post_rst_no_move", 32'(mv_seen), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] bits;
            bits = 4'($urandom);
            cycle(($urandom % 3) != 0, bits[0], bits[1], bits[2], bits[3], ($urandom % 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_move_scheduler.md
Name: ir_move_scheduler

Overview:
Controller between the IR direction decoder and the VGA sprite/cursor logic. Direction strobes arrive asynchronously to the display frame. The block queues them and applies at most one move per video frame, on Frame_Tick. It maintains a saturating on-screen position, so the drawing logic only ever sees position changes aligned to vblank.

Parameters:
DEPTH, 4, command queue entries (power of two, >=2)
STEP, 8, pixels moved per command
X_MAX, 639, maximum X coordinate
Y_MAX, 479, maximum Y coordinate
X_W, 10, Pos_X width
Y_W, 9, Pos_Y width

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Readable  in  1  direction inputs valid this cycle
Up  in  1  direction bit, qualified by Readable
Down  in  1  direction bit, qualified by Readable
Left  in  1  direction bit, qualified by Readable
Right  in  1  direction bit, qualified by Readable
Frame_Tick  in  1  one-cycle pulse at vblank start
Pos_X  out  X_W  current X position
Pos_Y  out  Y_W  current Y position
Move_Valid  out  1  one-cycle pulse; Pos_* changed this cycle
Overflow  out  1  one-cycle pulse; command dropped, queue full
Queue_Count  out  $clog2(DEPTH)+1  entries queued

Behaviour:
- Interface: one clock, Clock. Reset is asynchronous and active-high.
- Reset values: Pos_X=X_MAX/2 (319), Pos_Y=Y_MAX/2 floored (239), Move_Valid=0, Overflow=0, Queue_Count=0, state IDLE.
- Capture:
  - Applies in a cycle with Readable=1 and at least one direction bit set.
  - The direction is chosen by fixed priority Up>Down>Left>Right and encoded as dir_t.
  - Readable=1 with no bits set: ignored.
  - Direction bits with Readable=0: ignored.
- Push:
  - Queue not full: push encoded direction.
  - Queue full and no pop this cycle: drop the command, Overflow=1 next cycle, queue unchanged.
  - Queue full with a pop this cycle: push accepted, count unchanged.
- FSM:
  - IDLE: queue empty; Frame_Tick ignored. Goes to ARMED when count becomes non-zero.
  - ARMED: queue non-empty. Goes to APPLY on the edge that samples Frame_Tick=1.
  - APPLY: one cycle. At its closing edge, pop the head, update Pos_*, set Move_Valid=1 for the following cycle. Goes to ARMED if entries remain (counting a same-cycle push), else IDLE.
- Latency: Frame_Tick high in cycle N (state ARMED) gives new Pos and Move_Valid=1 in cycle N+2.
- Frame_Tick seen in APPLY is ignored: at most one move per tick.
- Arithmetic: computed one bit wider than the target, then clamped.
  - Up: Y = (Y<STEP) ? 0 : Y-STEP.
  - Down: Y = (Y+STEP>Y_MAX) ? Y_MAX : Y+STEP.
  - Left/Right: the same rules on X, using X_MAX.
  - No wrap-around at any edge.
- Queue order is FIFO. Pointers wrap modulo DEPTH. Queue_Count updates on the edge after a push/pop.
- Reset mid-operation: queue flushed and position re-centred immediately. No Move_Valid or Overflow pulse is emitted for discarded entries.

Decomposition:
- Package ir_pkg:
  - dir_t enum (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3).
  - sched_state_t enum (IDLE, ARMED, APPLY).
  - Default constants for STEP, X_MAX, Y_MAX.
- Sub-module ir_dir_fifo: DEPTH-entry, 2-bit-wide synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty, count; same asynchronous, active-high reset.
  - Simultaneous push+pop supported when full.
- The top level holds the priority encoder, FSM, and saturating position update.

Test Plan:
- Reset release: Pos_X=319, Pos_Y=239, Queue_Count=0, Move_Valid=0. Frame_Tick with empty queue gives no Move_Valid.
- One Readable+Right strobe, then Frame_Tick at cycle N: Pos_X=327 at N+2, Move_Valid high exactly one cycle, Queue_Count back to 0.
- Saturation: 40 Left commands, each followed by a Frame_Tick. Pos_X steps 319→7 by 8, the 40th move gives 0, and further Left moves keep 0. Repeat Down to Pos_Y=479.
- Multi-bit and invalid input:
  - Readable with Up=Left=1 queues Up only; after a tick, Pos_Y=231 and Pos_X unchanged.
  - Direction bits with Readable=0 are not queued.
- Overflow: 5 strobes (Up,Down,Left,Right,Up) with no tick. Overflow pulses on the 5th and Queue_Count=4. Four ticks then apply U,D,L,R in order; a 5th tick gives no Move_Valid.
- Corner timing and reset:
  - Push while full in an APPLY cycle is accepted with no Overflow.
  - Back-to-back Frame_Tick cycles give one move.
  - Reset asserted with 3 queued entries clears Queue_Count to 0 and Pos to (319,239), and no move appears after release.
